// File: rtl/obi_sram_bank_ctrl_if.sv
// rtl/obi_sram_bank_ctrl_if.sv - OBI request/response bundle between the system bus and one RAM bank
interface obi_sram_bank_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/obi_sram_bank_ctrl.sv
// rtl/obi_sram_bank_ctrl.sv - OBI slave to single-port SRAM bank with sleep/retention handshake
// Optional byte parity on the SRAM data path: define OBI_SRAM_PARITY_EN.
module obi_sram_bank_ctrl #(
    parameter int NUM_WORDS   = 8192,
    parameter int RD_LAT      = 1,
    parameter int WAKE_CYCLES = 4,
    localparam int ADDR_W     = $clog2(NUM_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    obi_sram_bank_ctrl_if.slave   obi,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [ADDR_W-1:0]     sram_addr_o,
    output logic [3:0]            sram_be_o,
`ifdef OBI_SRAM_PARITY_EN
    output logic [35:0]           sram_wdata_o,
    input  logic [35:0]           sram_rdata_i,
    output logic                  parity_err_o,
    output logic [7:0]            parity_err_cnt_o,
`else
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i,
`endif
    output logic                  sram_sleep_o,
    input  logic                  sleep_req_i,
    output logic                  sleep_ack_o
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SLEEP  = 2'd2,
        ST_WAKE   = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [7:0]        wake_cnt, wake_cnt_n;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_wr;
    logic              sleep_q;
    logic              accept;
    logic              rsp_is_read;

    // Address bits above the bank and the byte offset are decoded upstream.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{obi.addr[31:ADDR_W+2], obi.addr[1:0]};

    assign obi.gnt      = obi.req && (state == ST_ACTIVE);
    assign accept       = obi.req && obi.gnt;

    assign sram_req_o   = accept;
    assign sram_we_o    = obi.we;
    assign sram_addr_o  = obi.addr[ADDR_W+1:2];
    assign sram_be_o    = obi.we ? obi.be : 4'hF;

`ifdef OBI_SRAM_PARITY_EN
    assign sram_wdata_o = {^obi.wdata[31:24], ^obi.wdata[23:16],
                           ^obi.wdata[15:8],  ^obi.wdata[7:0], obi.wdata};
`else
    assign sram_wdata_o = obi.wdata;
`endif

    // The oldest pipeline stage lines up with the SRAM read data.
    assign obi.rvalid   = pipe_vld[RD_LAT-1];
    assign rsp_is_read  = pipe_vld[RD_LAT-1] && !pipe_wr[RD_LAT-1];
    assign obi.rdata    = rsp_is_read ? sram_rdata_i[31:0] : 32'h0;

    assign sram_sleep_o = sleep_q;
    assign sleep_ack_o  = sleep_q;

    always_comb begin
        state_n    = state;
        wake_cnt_n = wake_cnt;
        unique case (state)
            ST_ACTIVE: begin
                if (sleep_req_i) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!sleep_req_i)          state_n = ST_ACTIVE;
                else if (pipe_vld == '0)   state_n = ST_SLEEP;
            end
            ST_SLEEP: begin
                if (!sleep_req_i) begin
                    state_n    = ST_WAKE;
                    wake_cnt_n = 8'(WAKE_CYCLES - 1);
                end
            end
            ST_WAKE: begin
                if (wake_cnt == 8'd0) state_n    = ST_ACTIVE;
                else                  wake_cnt_n = wake_cnt - 8'd1;
            end
            default: state_n = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_ACTIVE;
            wake_cnt <= 8'd0;
            pipe_vld <= '0;
            pipe_wr  <= '0;
            sleep_q  <= 1'b0;
        end else begin
            state    <= state_n;
            wake_cnt <= wake_cnt_n;
            sleep_q  <= (state_n == ST_SLEEP);
            pipe_vld[0] <= accept;
            pipe_wr[0]  <= obi.we;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_wr[i]  <= pipe_wr[i-1];
            end
        end
    end

`ifdef OBI_SRAM_PARITY_EN
    logic [3:0] par_mismatch;

    always_comb begin
        par_mismatch = '0;
        for (int k = 0; k < 4; k++) begin
            par_mismatch[k] = (^sram_rdata_i[8*k +: 8]) ^ sram_rdata_i[32+k];
        end
    end

    assign parity_err_o = rsp_is_read && (par_mismatch != 4'h0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_err_cnt_o <= 8'd0;
        end else if (parity_err_o && (parity_err_cnt_o != 8'hFF)) begin
            parity_err_cnt_o <= parity_err_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_obi_sram_bank_ctrl.sv
// tb/tb_obi_sram_bank_ctrl.sv - directed plus random checks of obi_sram_bank_ctrl against a queue model
module tb_obi_sram_bank_ctrl;
    localparam int NUM_WORDS   = 256;
    localparam int RD_LAT      = 3;
    localparam int WAKE_CYCLES = 4;
    localparam int ADDR_W      = $clog2(NUM_WORDS);
`ifdef OBI_SRAM_PARITY_EN
    localparam int DW = 36;
`else
    localparam int DW = 32;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              sleep_req;
    logic              sleep_ack;
    logic              sram_sleep;
    logic              sram_req;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [3:0]        sram_be;
    logic [DW-1:0]     sram_wdata;
    logic [DW-1:0]     sram_rdata;
    logic [DW-1:0]     flip_mask;
`ifdef OBI_SRAM_PARITY_EN
    logic              parity_err;
    logic [7:0]        parity_err_cnt;
`endif

    obi_sram_bank_ctrl_if bus();

    always #5 clk = ~clk;

    obi_sram_bank_ctrl #(
        .NUM_WORDS   (NUM_WORDS),
        .RD_LAT      (RD_LAT),
        .WAKE_CYCLES (WAKE_CYCLES)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .obi              (bus),
        .sram_req_o       (sram_req),
        .sram_we_o        (sram_we),
        .sram_addr_o      (sram_addr),
        .sram_be_o        (sram_be),
        .sram_wdata_o     (sram_wdata),
        .sram_rdata_i     (sram_rdata),
`ifdef OBI_SRAM_PARITY_EN
        .parity_err_o     (parity_err),
        .parity_err_cnt_o (parity_err_cnt),
`endif
        .sram_sleep_o     (sram_sleep),
        .sleep_req_i      (sleep_req),
        .sleep_ack_o      (sleep_ack)
    );

    // SRAM macro model: byte-lane writes, read data appears RD_LAT cycles after the access.
    logic [DW-1:0] mem   [NUM_WORDS];
    logic [DW-1:0] rpipe [RD_LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
        end else if (sram_req) begin
            if (sram_we) begin
                for (int k = 0; k < 4; k++) begin
                    if (sram_be[k]) begin
                        mem[sram_addr][8*k +: 8] <= sram_wdata[8*k +: 8];
`ifdef OBI_SRAM_PARITY_EN
                        mem[sram_addr][32+k] <= sram_wdata[32+k];
`endif
                    end
                end
            end else begin
                rpipe[0] <= mem[sram_addr];
            end
        end
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign sram_rdata = rpipe[RD_LAT-1] ^ flip_mask;

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          wr;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] shadow [NUM_WORDS];
    int          cyc;
    int          n_vec;
    int          n_err;
    bit          exp_active;
    int          exp_perr_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bus cycle: compare against the model mid-cycle, then let the clock edge happen.
    task automatic step();
        bit          exp_g;
        bit          exp_rv;
        rsp_t        r;
        int unsigned widx;
        @(negedge clk);
        exp_g = bus.req && exp_active;
        widx  = (bus.addr >> 2) % NUM_WORDS;
        chk("gnt", 32'(bus.gnt), 32'(exp_g));
        chk("sram_req", 32'(sram_req), 32'(exp_g));
        if (exp_g) begin
            chk("sram_addr", 32'(sram_addr), widx);
            chk("sram_we", 32'(sram_we), 32'(bus.we));
            chk("sram_be", 32'(sram_be), bus.we ? 32'(bus.be) : 32'hF);
`ifdef OBI_SRAM_PARITY_EN
            chk("wparity", 32'(sram_wdata[35:32]),
                32'({^bus.wdata[31:24], ^bus.wdata[23:16], ^bus.wdata[15:8], ^bus.wdata[7:0]}));
`endif
        end
        exp_rv = (q.size() > 0) && (q[0].due == cyc);
        chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
        if (exp_rv) begin
            r = q.pop_front();
            chk("rdata", bus.rdata, r.data);
`ifdef OBI_SRAM_PARITY_EN
            chk("parity_err", 32'(parity_err), 32'(!r.wr && (flip_mask != '0)));
            if (!r.wr && (flip_mask != '0) && exp_perr_cnt < 255) exp_perr_cnt++;
`endif
        end
        if (exp_g) begin
            r.due  = cyc + RD_LAT;
            r.wr   = bus.we;
            r.data = bus.we ? 32'h0 : shadow[widx];
            q.push_back(r);
            if (bus.we) begin
                for (int k = 0; k < 4; k++)
                    if (bus.be[k]) shadow[widx][8*k +: 8] = bus.wdata[8*k +: 8];
            end
        end
        if (rst) begin
            q.delete();
            for (int i = 0; i < NUM_WORDS; i++) shadow[i] = 32'h0;
            exp_perr_cnt = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.be    = be;
        bus.wdata = wdata;
        step();
        bus.req   = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'h0);
        chk({tag, "_rdata"}, bus.rdata, 32'h0);
        chk({tag, "_sram_sleep"}, 32'(sram_sleep), 32'h0);
        chk({tag, "_sleep_ack"}, 32'(sleep_ack), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0; n_vec = 0; n_err = 0; exp_active = 1'b1; exp_perr_cnt = 0;
        flip_mask = '0;
        rst = 1'b1; sleep_req = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.be = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
        for (int i = 0; i < NUM_WORDS; i++) shadow[i] = 32'h0;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Full-word write then read of byte address 0x10 (word 4).
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        idle(RD_LAT + 1);

        // Single-lane byte write merges into the existing word.
        issue(1'b1, 32'h20, 4'hF, 32'h11223344);
        issue(1'b1, 32'h20, 4'b0010, 32'h0000AA00);
        issue(1'b0, 32'h20, 4'h0, 32'h0);
        idle(RD_LAT + 1);
        chk("byte_merge_model", shadow[8], 32'h1122AA44);

        // Eight back-to-back reads: rvalids must follow with no bubbles.
        for (int i = 0; i < 8; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0);
        idle(RD_LAT + 1);

        // Sleep handshake with reads in flight and a request stalled while parked.
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        issue(1'b0, 32'h20, 4'h0, 32'h0);
        sleep_req = 1'b1;
        issue(1'b0, 32'h0, 4'h0, 32'h0);
        exp_active = 1'b0;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h10;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("ack_before_drained", 32'(sleep_ack && (q.size() != 0)), 32'h0);
            if (sleep_ack) break;
        end
        chk("sleep_ack_rise", 32'(sleep_ack), 32'h1);
        chk("sram_sleep_rise", 32'(sram_sleep), 32'h1);
        chk("drained", 32'(q.size()), 32'h0);
        step(); step();
        chk("sleep_hold", 32'(sleep_ack), 32'h1);
        sleep_req = 1'b0;
        step();
        chk("wake_ack_low", 32'(sleep_ack), 32'h0);
        chk("wake_sram_sleep_low", 32'(sram_sleep), 32'h0);
        for (int w = 0; w < WAKE_CYCLES; w++) begin
            if (w == 1) sleep_req = 1'b1;
            if (w == 2) sleep_req = 1'b0;
            step();
        end
        exp_active = 1'b1;
        step();
        idle(RD_LAT + 1);

        // Reset one cycle after a read grant drops its response.
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("midreset");
        idle(RD_LAT + 1);

        // Random traffic, including ignored upper address bits.
        for (int i = 0; i < 400; i++) begin
            bus.req   = 1'($urandom_range(0, 1));
            bus.we    = 1'($urandom_range(0, 1));
            bus.be    = 4'($urandom);
            bus.addr  = $urandom;
            bus.wdata = $urandom;
            step();
        end
        idle(RD_LAT + 1);

`ifdef OBI_SRAM_PARITY_EN
        chk("perr_cnt_clean", 32'(parity_err_cnt), 32'h0);
        flip_mask = '0;
        flip_mask[33] = 1'b1;
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        idle(RD_LAT + 1);
        chk("perr_cnt_one", 32'(parity_err_cnt), 32'h1);
        for (int i = 0; i < 299; i++) issue(1'b0, 32'($urandom), 4'h0, 32'h0);
        idle(RD_LAT + 1);
        chk("perr_cnt_sat", 32'(parity_err_cnt), 32'(exp_perr_cnt));
        chk("perr_cnt_255", 32'(parity_err_cnt), 32'd255);
        flip_mask = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
